// File: rtl/compress_q_if.sv
// compress_q_if: stream bundle for the Kyber coefficient compressor.
//   in_valid / in_ready / in_data        : 12-bit coefficient input stream
//   out_valid / out_ready / out_data/err : D-bit compressed output stream
// slave modport is the compressor's view; master is the environment's view.
interface compress_q_if #(
    parameter int D = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [11:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] out_data;
    logic         out_err;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/compress_q.sv
// compress_q: pipelined Kyber coefficient compressor.
//   y = floor(((xr << D) + 1664) / 3329) mod 2^D, xr = x reduced once mod Q.
// Division is done by multiply-shift with M = floor(2^24/Q) followed by a
// single remainder correction.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : compress_q_if.slave (input stream in, compressed stream out)
// Register chain: S1 (captured x) -> S2 (n, err) -> S3 (n, qe, err)
//                 -> S4 (qe, r, err) -> output register (y, err).
// A sample accepted on edge t is presented on out_valid after edge t+4.
module compress_q #(
    parameter int D = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    compress_q_if.slave bus
);
    localparam int Q = 3329;
    localparam int M = 5039;

    generate
        if (D < 1 || D > 11) begin : g_bad_d
            $error("compress_q: D must be in 1..11");
        end
    endgenerate

    logic         w_en;

    logic         r_s1_valid;
    logic [11:0]  r_s1_x;

    logic         r_s2_valid;
    logic [22:0]  r_s2_n;
    logic         r_s2_err;

    logic         r_s3_valid;
    logic [22:0]  r_s3_n;
    logic [11:0]  r_s3_qe;
    logic         r_s3_err;

    logic         r_s4_valid;
    logic [11:0]  r_s4_qe;
    logic [12:0]  r_s4_r;
    logic         r_s4_err;

    logic         r_out_valid;
    logic [D-1:0] r_out_data;
    logic         r_out_err;

    logic         w_s1_err;
    logic [11:0]  w_s1_xr;
    logic [22:0]  w_s1_n;
    logic [11:0]  w_s2_qe;
    logic [12:0]  w_s3_r;
    logic [D-1:0] w_s4_y;

    // Whole pipe moves together; it only freezes when the output is held.
    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    assign w_s1_err = (r_s1_x >= 12'(Q));
    assign w_s1_xr  = w_s1_err ? (r_s1_x - 12'(Q)) : r_s1_x;
    assign w_s1_n   = (23'(w_s1_xr) << D) + 23'd1664;

    // qe is floor(n/Q) or one less: M underestimates 2^24/Q by < 1 and n < 2^23,
    // so the truncation error of n*M/2^24 stays below 0.5.
    assign w_s2_qe = 12'((36'(r_s2_n) * 36'(M)) >> 24);

    // Remainder lies in [0, 2Q) and therefore fits in 13 bits.
    assign w_s3_r = 13'(24'(r_s3_n) - (24'(r_s3_qe) * 24'(Q)));

    assign w_s4_y = D'(r_s4_qe + 12'(r_s4_r >= 13'(Q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_x      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_n      <= '0;
            r_s2_err    <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s3_n      <= '0;
            r_s3_qe     <= '0;
            r_s3_err    <= 1'b0;
            r_s4_valid  <= 1'b0;
            r_s4_qe     <= '0;
            r_s4_r      <= '0;
            r_s4_err    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid;
            r_s1_x      <= bus.in_data;

            r_s2_valid  <= r_s1_valid;
            r_s2_n      <= w_s1_n;
            r_s2_err    <= w_s1_err;

            r_s3_valid  <= r_s2_valid;
            r_s3_n      <= r_s2_n;
            r_s3_qe     <= w_s2_qe;
            r_s3_err    <= r_s2_err;

            r_s4_valid  <= r_s3_valid;
            r_s4_qe     <= r_s3_qe;
            r_s4_r      <= w_s3_r;
            r_s4_err    <= r_s3_err;

            r_out_valid <= r_s4_valid;
            // Output word only changes when a real sample lands, so it holds
            // its last value across bubbles.
            if (r_s4_valid) begin
                r_out_data <= w_s4_y;
                r_out_err  <= r_s4_err;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_compress_q.sv
// Bench for compress_q: five instances (D = 1, 4, 5, 10, 11) share one input
// stream and one out_ready. A queue-based reference model predicts every
// emitted word from the arithmetic definition of compression.
module tb_compress_q;
    localparam int NL = 5;

    function automatic int d_of(int g);
        case (g)
            0:       return 1;
            1:       return 4;
            2:       return 5;
            3:       return 10;
            default: return 11;
        endcase
    endfunction

    function automatic int golden(int x, int d);
        int xr;
        xr = (x >= 3329) ? x - 3329 : x;
        return (((xr << d) + 1664) / 3329) % (1 << d);
    endfunction

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic        out_ready;

    logic        lane_valid [NL];
    logic        lane_ready [NL];
    logic        lane_err   [NL];
    logic [10:0] lane_data  [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int DG = d_of(g);
        compress_q_if #(.D(DG)) bus ();
        compress_q #(.D(DG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.out_ready = out_ready;
        assign lane_valid[g] = bus.out_valid;
        assign lane_ready[g] = bus.in_ready;
        assign lane_err[g]   = bus.out_err;
        assign lane_data[g]  = 11'(bus.out_data);
    end

    typedef struct {
        int x;
        int acc_cyc;
        int stl;
    } item_t;

    item_t q[$];
    int    log_d [NL][$];
    int    log_e [NL][$];
    int    last_out [NL];
    int    prev_data [NL];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    stalls = 0;
    bit    prev_stall = 0;
    bit    head_seen = 0;
    bit    saw_low = 0;
    int    mode = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       out_ready = 1;
                2:       out_ready = 0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(string name, int lane, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s lane%0d: got %0d expected %0d (t=%0t)", name, lane, act, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < NL; g++) begin
                chk("in_ready_rule", g, int'(lane_ready[g]), int'(!lane_valid[g] || out_ready));
                chk("valid_match", g, int'(lane_valid[g]), int'(lane_valid[0]));
            end
            if (!lane_ready[0]) saw_low = 1;
            if (prev_stall) begin
                for (int g = 0; g < NL; g++) begin
                    chk("stall_valid", g, int'(lane_valid[g]), 1);
                    chk("stall_stable", g, int'(lane_data[g]), prev_data[g]);
                end
            end
            if (!lane_valid[0]) begin
                for (int g = 0; g < NL; g++)
                    chk("bubble_hold", g, int'(lane_data[g]), last_out[g]);
            end else if (q.size() == 0) begin
                fail_now("stale_output");
            end else begin
                if (!head_seen) begin
                    chk("latency", 0, cyc - q[0].acc_cyc, 4 + stalls - q[0].stl);
                    head_seen = 1;
                end
                for (int g = 0; g < NL; g++) begin
                    chk("data", g, int'(lane_data[g]), golden(q[0].x, d_of(g)));
                    chk("err", g, int'(lane_err[g]), int'(q[0].x >= 3329));
                end
                if (out_ready) begin
                    for (int g = 0; g < NL; g++) begin
                        log_d[g].push_back(int'(lane_data[g]));
                        log_e[g].push_back(int'(lane_err[g]));
                    end
                    void'(q.pop_front());
                    head_seen = 0;
                end
            end
            if (lane_valid[0]) begin
                for (int g = 0; g < NL; g++) last_out[g] = int'(lane_data[g]);
            end
            for (int g = 0; g < NL; g++) prev_data[g] = int'(lane_data[g]);
            prev_stall = lane_valid[0] && !out_ready;
            if (prev_stall) stalls++;
            if (in_valid && lane_ready[0])
                q.push_back('{x: int'(in_data), acc_cyc: cyc + 1, stl: stalls});
            chk("in_flight_max", 0, int'(q.size() <= 5), 1);
        end
    end

    task automatic push(int x);
        int n;
        n = 0;
        in_valid = 1;
        in_data  = 12'(x);
        @(negedge clk);
        while (!lane_ready[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("push_timeout");
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic idle();
        in_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || lane_valid[0]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int g = 0; g < NL; g++) begin
            log_d[g].delete();
            log_e[g].delete();
        end
    endtask

    task automatic chk_log(string name, int lane, int idx, int exp_d, int exp_e);
        if (idx >= log_d[lane].size()) begin
            fail_now(name);
        end else begin
            chk(name, lane, log_d[lane][idx], exp_d);
            chk(name, lane, log_e[lane][idx], exp_e);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_seen  = 0;
        prev_stall = 0;
        for (int g = 0; g < NL; g++) last_out[g] = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int a_x[5];
        a_x = '{0, 208, 1664, 1665, 3328};
        in_valid = 0;
        in_data  = 0;
        rst_n    = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;

        @(negedge clk);
        for (int g = 0; g < NL; g++) begin
            chk("rst_valid", g, int'(lane_valid[g]), 0);
            chk("rst_data", g, int'(lane_data[g]), 0);
            chk("rst_err", g, int'(lane_err[g]), 0);
            chk("rst_in_ready", g, int'(lane_ready[g]), 1);
        end
        @(posedge clk);
        #1;

        // D=4 sequence with out_ready high.
        clear_logs();
        for (int i = 0; i < 5; i++) push(a_x[i]);
        drain();
        chk_log("d4_seq0", 1, 0, 0, 0);
        chk_log("d4_seq1", 1, 1, 1, 0);
        chk_log("d4_seq2", 1, 2, 8, 0);
        chk_log("d4_seq3", 1, 3, 8, 0);
        chk_log("d4_seq4", 1, 4, 0, 0);

        // Out-of-range inputs.
        clear_logs();
        push(3329);
        push(4095);
        drain();
        chk_log("d4_err0", 1, 0, 0, 1);
        chk_log("d4_err1", 1, 1, 4, 1);

        // Wide output widths.
        clear_logs();
        push(1000);
        push(3000);
        push(3328);
        drain();
        chk_log("d10_1000", 3, 0, 308, 0);
        chk_log("d11_3000", 4, 1, 1846, 0);
        chk_log("d11_3328", 4, 2, 2047, 0);

        // Backpressure: out_ready low for about 5 cycles under continuous input.
        clear_logs();
        saw_low = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) push(100 + i * 397);
            end
            begin
                int n;
                n = 0;
                while (!lane_valid[0] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) fail_now("bp_wait_timeout");
                mode = 2;
                repeat (6) @(posedge clk);
                mode = 0;
            end
        join
        drain();
        chk("bp_count", 3, log_d[3].size(), 10);
        chk("bp_in_ready_low", 0, int'(saw_low), 1);

        // Mid-stream reset with samples in flight and an output pending.
        clear_logs();
        for (int i = 0; i < 4; i++) push(500 + i);
        idle();
        chk("pre_rst_valid", 0, int'(lane_valid[0]), 1);
        #3;
        rst_n = 0;
        #1;
        for (int g = 0; g < NL; g++) begin
            chk("mid_rst_valid", g, int'(lane_valid[g]), 0);
            chk("mid_rst_data", g, int'(lane_data[g]), 0);
        end
        model_reset();
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        push(1000);
        drain();
        chk("post_rst_count", 3, log_d[3].size(), 1);
        chk_log("post_rst_1000", 3, 0, 308, 0);

        // Full sweep with random gaps and random out_ready.
        mode = 1;
        for (int x = 0; x < 4096; x++) begin
            if ($urandom_range(0, 3) == 0) idle();
            push(x);
        end
        mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/compress_q.md
Name: compress_q

Overview:
- Pipelined Kyber coefficient compressor; inverse of the decompress block.
- Maps a 12-bit coefficient x in Z_3329 to a D-bit value: y = floor(((x << D) + 1664) / 3329) mod 2^D.
- Used on the encryption output path (u with D=10/11, v with D=4/5) before ciphertext packing.
- Streams one coefficient per cycle with valid/ready backpressure; division is done by multiply-shift plus one correction step (no divider).

Parameters:
- D, 4, output bit width; legal range 1..11. Other values: elaboration error.
- Q, 3329, Kyber modulus. localparam, not overridable.
- M, 5039, floor(2^24/Q). localparam.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  12  coefficient x.
- out_valid  output  1  out_data / out_err are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  D  compressed value y.
- out_err  output  1  input for this result was >= Q.

Behaviour:
- Reset: the asynchronous assert clears all stage valid bits, out_valid, out_data and out_err to 0. Reset mid-stream discards all in-flight samples. in_ready is high while in reset-release idle.
- Transfers occur on clock edges where valid && ready.
- Pipeline has 4 stages, S1..S4, each with its own valid bit.
  - Global advance enable: en = !out_valid || out_ready.
  - When en=0, all stages hold their contents.
  - in_ready = en. This is combinational from out_ready/out_valid and must not depend on in_valid.
- Latency: a sample accepted at edge t appears at out_valid at edge t+4 when there are no stalls. Throughput is 1 per cycle with out_ready held high.
- S1:
  - xr = (x >= Q) ? x - Q : x.
  - err = (x >= Q).
  - n = (xr << D) + 1664. n is 23 bits; max value 3328*2^11 + 1664 < 2^23.
- S2: p = n * M (36 bits); qe = p >> 24. qe is floor(n/Q) or floor(n/Q) - 1.
- S3: r = n - qe*Q, 13 bits unsigned, range [0, 2Q).
- S4:
  - qf = qe + (r >= Q).
  - out_data = qf[D-1:0], i.e. mod 2^D.
  - out_err = err.
- Bubbles: stages with valid=0 still advance when en=1. Data in bubble stages is don't-care, but out_data must hold its last value while out_valid=0.
- Simultaneous accept and emit in the same cycle is permitted with no bubble inserted.
- out_data and out_err must stay stable while out_valid=1 and out_ready=0.
- All arithmetic is unsigned. No rounding-tie case exists because Q is odd.

Test Plan:
- D=4, stream x = 0, 208, 1664, 1665, 3328 with out_ready=1 → out_data = 0, 1, 8, 8, 0. out_valid is first high 4 cycles after the first accept; out_err=0 throughout.
- D=4, x = 3329 and x = 4095 → out_data = 0 and 4 respectively (computed on 0 and 766), out_err=1 for both.
- D=10, x=1000 → 308. D=11, x=3000 → 1846; x=3328 → 2047.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 continuously. Required:
  - in_ready drops once S4 is full.
  - No sample is lost or duplicated.
  - Output order matches input order.
  - out_data is stable while stalled.
- Exhaustive: for D in {1, 4, 5, 10, 11}, sweep x = 0..4095 with random out_ready. Compare against a golden floor((xr*2^D + 1664)/3329) mod 2^D plus the err flag.
- Assert rst_n mid-stream with 3 samples in flight → out_valid=0 immediately. After release, no stale sample emerges and the next input yields the correct result at 4-cycle latency.
